// File: rtl/max_reduce_int_nbit_if.sv
// Stream bundle for max_reduce_int_nbit: element input beats and the per-vector
// result, each with its own valid/ready handshake.
interface max_reduce_int_nbit_if #(
    parameter int WIDTH     = 32,
    parameter int IDX_WIDTH = 16
);
    logic                 mode_min;
    logic [WIDTH-1:0]     in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic                 in_last;
    logic [WIDTH-1:0]     out_data;
    logic [IDX_WIDTH-1:0] out_idx;
    logic [IDX_WIDTH-1:0] out_count;
    logic                 out_ovf;
    logic                 out_valid;
    logic                 out_ready;

    modport master (
        output mode_min, in_data, in_valid, in_last, out_ready,
        input  in_ready, out_data, out_idx, out_count, out_ovf, out_valid
    );

    modport slave (
        input  mode_min, in_data, in_valid, in_last, out_ready,
        output in_ready, out_data, out_idx, out_count, out_ovf, out_valid
    );
endinterface

// File: rtl/max_reduce_int_nbit.sv
// Streaming max/min reduction with argmax over variable-length integer vectors.
// One result per vector; at least one bubble cycle between vectors.
module max_reduce_int_nbit #(
    parameter int WIDTH     = 32,
    parameter int IDX_WIDTH = 16,
    parameter int SIGNED    = 1,
    parameter int IMPL_TYPE = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    max_reduce_int_nbit_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    localparam logic MSB_FLIP = (SIGNED == 0);

    state_t               state, state_nxt;
    logic                 in_ready_c;
    logic                 out_valid_c;
    logic                 accept;
    logic                 replace;
    logic                 mode_q;
    logic [WIDTH-1:0]     best;
    logic [IDX_WIDTH-1:0] best_idx;
    logic [IDX_WIDTH-1:0] cnt;
    logic                 ovf;
    logic signed [WIDTH-1:0] cur_s, best_s;

    // Two's-complement a > b; IMPL_TYPE 1 uses the borrow of a widened b - a.
    function automatic logic gt_int_nbit(input logic signed [WIDTH-1:0] a,
                                         input logic signed [WIDTH-1:0] b);
        logic signed [WIDTH:0] diff;
        diff = $signed({b[WIDTH-1], b}) - $signed({a[WIDTH-1], a});
        if (IMPL_TYPE == 1)
            return diff[WIDTH];
        return a > b;
    endfunction

    // Unsigned order maps onto signed order by inverting the MSB of both operands.
    assign cur_s   = $signed({bus.in_data[WIDTH-1] ^ MSB_FLIP, bus.in_data[WIDTH-2:0]});
    assign best_s  = $signed({best[WIDTH-1] ^ MSB_FLIP, best[WIDTH-2:0]});
    assign replace = mode_q ? gt_int_nbit(best_s, cur_s) : gt_int_nbit(cur_s, best_s);
    assign accept  = bus.in_valid && (state != DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        in_ready_c  = 1'b1;
        out_valid_c = 1'b0;
        case (state)
            IDLE: if (accept) state_nxt = bus.in_last ? DONE : ACC;
            ACC:  if (accept && bus.in_last) state_nxt = DONE;
            DONE: begin
                in_ready_c  = 1'b0;
                out_valid_c = 1'b1;
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Strict compare keeps the earliest of equal extremes; ovf marks a count wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best     <= '0;
            best_idx <= '0;
            cnt      <= '0;
            ovf      <= 1'b0;
            mode_q   <= 1'b0;
        end else if (accept) begin
            if (state == IDLE) begin
                best     <= bus.in_data;
                best_idx <= '0;
                cnt      <= {{(IDX_WIDTH-1){1'b0}}, 1'b1};
                ovf      <= 1'b0;
                mode_q   <= bus.mode_min;
            end else begin
                if (replace) begin
                    best     <= bus.in_data;
                    best_idx <= cnt;
                end
                cnt <= cnt + 1'b1;
                if (cnt == '1)
                    ovf <= 1'b1;
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.out_data  = best;
    assign bus.out_idx   = best_idx;
    assign bus.out_count = cnt;
    assign bus.out_ovf   = ovf;
endmodule

// File: tb/tb_max_reduce_int_nbit.sv
// Directed bench for max_reduce_int_nbit: signed, unsigned and narrow-index
// instances driven with hand-computed vectors.
module tb_max_reduce_int_nbit;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    max_reduce_int_nbit_if #(.WIDTH(32), .IDX_WIDTH(16)) ia ();
    max_reduce_int_nbit_if #(.WIDTH(32), .IDX_WIDTH(16)) iu ();
    max_reduce_int_nbit_if #(.WIDTH(32), .IDX_WIDTH(4))  io ();

    max_reduce_int_nbit #(.WIDTH(32), .IDX_WIDTH(16), .SIGNED(1), .IMPL_TYPE(0))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));
    max_reduce_int_nbit #(.WIDTH(32), .IDX_WIDTH(16), .SIGNED(0), .IMPL_TYPE(1))
        dut_u (.clk(clk), .rst_n(rst_n), .bus(iu));
    max_reduce_int_nbit #(.WIDTH(32), .IDX_WIDTH(4), .SIGNED(1), .IMPL_TYPE(0))
        dut_o (.clk(clk), .rst_n(rst_n), .bus(io));

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // gap idle cycles carry junk data, in_last=1 and the opposite mode, none of which may be taken
    task automatic beat_a(input logic [31:0] d, input logic last, input logic mn, input int gap);
        repeat (gap) begin
            ia.in_valid = 1'b0; ia.in_last = 1'b1; ia.in_data = 32'hDEADBEEF; ia.mode_min = ~mn;
            @(posedge clk); #1;
        end
        ia.in_data = d; ia.in_last = last; ia.mode_min = mn; ia.in_valid = 1'b1;
        @(posedge clk); #1;
        ia.in_valid = 1'b0; ia.in_last = 1'b0;
    endtask

    task automatic take_a(input string tag, input logic [31:0] d, input logic [15:0] idx,
                          input logic [15:0] cnt, input logic ovf);
        chk({tag, ".valid"}, 64'(ia.out_valid), 64'd1);
        chk({tag, ".data"},  64'(ia.out_data),  64'(d));
        chk({tag, ".idx"},   64'(ia.out_idx),   64'(idx));
        chk({tag, ".count"}, 64'(ia.out_count), 64'(cnt));
        chk({tag, ".ovf"},   64'(ia.out_ovf),   64'(ovf));
        ia.out_ready = 1'b1;
        @(posedge clk); #1;
        ia.out_ready = 1'b0;
        chk({tag, ".valid_drop"}, 64'(ia.out_valid), 64'd0);
        chk({tag, ".ready_back"}, 64'(ia.in_ready),  64'd1);
    endtask

    task automatic beat_u(input logic [31:0] d, input logic last);
        iu.in_data = d; iu.in_last = last; iu.mode_min = 1'b0; iu.in_valid = 1'b1;
        @(posedge clk); #1;
        iu.in_valid = 1'b0; iu.in_last = 1'b0;
    endtask

    task automatic beat_o(input logic [31:0] d, input logic last);
        io.in_data = d; io.in_last = last; io.mode_min = 1'b0; io.in_valid = 1'b1;
        @(posedge clk); #1;
        io.in_valid = 1'b0; io.in_last = 1'b0;
    endtask

    initial begin
        ia.in_valid = 1'b0; ia.in_last = 1'b0; ia.in_data = '0; ia.mode_min = 1'b0; ia.out_ready = 1'b0;
        iu.in_valid = 1'b0; iu.in_last = 1'b0; iu.in_data = '0; iu.mode_min = 1'b0; iu.out_ready = 1'b0;
        io.in_valid = 1'b0; io.in_last = 1'b0; io.in_data = '0; io.mode_min = 1'b0; io.out_ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.in_ready",  64'(ia.in_ready),  64'd1);
        chk("rst.out_valid", 64'(ia.out_valid), 64'd0);
        chk("rst.out_data",  64'(ia.out_data),  64'd0);
        chk("rst.out_idx",   64'(ia.out_idx),   64'd0);
        chk("rst.out_count", 64'(ia.out_count), 64'd0);
        chk("rst.out_ovf",   64'(ia.out_ovf),   64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // signed max with both extremes of the range present
        beat_a(32'd5, 1'b0, 1'b0, 0);
        beat_a(32'hFFFFFFFD, 1'b0, 1'b0, 0);
        beat_a(32'h7FFFFFFF, 1'b0, 1'b0, 0);
        beat_a(32'h80000000, 1'b0, 1'b0, 0);
        beat_a(32'd7, 1'b1, 1'b0, 0);
        take_a("smax", 32'h7FFFFFFF, 16'd2, 16'd5, 1'b0);

        // signed min vs unsigned max on the same data
        beat_a(32'h00000001, 1'b0, 1'b1, 0);
        beat_a(32'hFFFFFFFF, 1'b0, 1'b1, 0);
        beat_a(32'h80000000, 1'b1, 1'b1, 0);
        take_a("smin", 32'h80000000, 16'd2, 16'd3, 1'b0);

        beat_u(32'h00000001, 1'b0);
        beat_u(32'hFFFFFFFF, 1'b0);
        beat_u(32'h80000000, 1'b1);
        chk("umax.valid", 64'(iu.out_valid), 64'd1);
        chk("umax.data",  64'(iu.out_data),  64'hFFFFFFFF);
        chk("umax.idx",   64'(iu.out_idx),   64'd1);
        chk("umax.count", 64'(iu.out_count), 64'd3);
        iu.out_ready = 1'b1;
        @(posedge clk); #1;
        iu.out_ready = 1'b0;
        chk("umax.valid_drop", 64'(iu.out_valid), 64'd0);

        // ties keep the earliest index
        beat_a(32'd4, 1'b0, 1'b0, 0);
        beat_a(32'd9, 1'b0, 1'b0, 0);
        beat_a(32'd9, 1'b0, 1'b0, 0);
        beat_a(32'd2, 1'b0, 1'b0, 0);
        beat_a(32'd9, 1'b1, 1'b0, 0);
        take_a("tie", 32'd9, 16'd1, 16'd5, 1'b0);

        beat_a(32'hFFFFFFF8, 1'b1, 1'b0, 0);
        take_a("single", 32'hFFFFFFF8, 16'd0, 16'd1, 1'b0);

        // backpressure: upstream keeps offering while the result is stalled
        beat_a(32'd3, 1'b0, 1'b0, 0);
        beat_a(32'd10, 1'b1, 1'b0, 0);
        ia.in_valid = 1'b1; ia.in_data = 32'd100; ia.in_last = 1'b1; ia.mode_min = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("bp.in_ready",  64'(ia.in_ready),  64'd0);
            chk("bp.out_valid", 64'(ia.out_valid), 64'd1);
            chk("bp.out_data",  64'(ia.out_data),  64'd10);
            @(posedge clk); #1;
        end
        chk("bp.out_idx",   64'(ia.out_idx),   64'd1);
        chk("bp.out_count", 64'(ia.out_count), 64'd2);
        ia.in_data = 32'd50; ia.out_ready = 1'b1;
        @(posedge clk); #1;
        ia.out_ready = 1'b0;
        chk("bp.xfer_valid", 64'(ia.out_valid), 64'd0);
        chk("bp.xfer_ready", 64'(ia.in_ready),  64'd1);
        @(posedge clk); #1;
        ia.in_valid = 1'b0; ia.in_last = 1'b0;
        take_a("bp_next", 32'd50, 16'd0, 16'd1, 1'b0);

        // min latched on first beat; mode flips and bubbles afterwards are ignored
        beat_a(32'd20, 1'b0, 1'b1, int'($urandom_range(0, 3)));
        beat_a(32'hFFFFFFFB, 1'b0, 1'b0, int'($urandom_range(0, 3)));
        beat_a(32'd30, 1'b0, 1'b0, int'($urandom_range(0, 3)));
        beat_a(32'hFFFFFFF9, 1'b0, 1'b1, int'($urandom_range(0, 3)));
        beat_a(32'd1, 1'b1, 1'b0, int'($urandom_range(1, 3)));
        take_a("latch", 32'hFFFFFFF9, 16'd3, 16'd5, 1'b0);

        // asynchronous reset mid-vector
        beat_a(32'd100, 1'b0, 1'b0, 0);
        beat_a(32'd200, 1'b0, 1'b0, 0);
        beat_a(32'd300, 1'b0, 1'b0, 0);
        chk("mid.pre_data", 64'(ia.out_data), 64'd300);
        #2 rst_n = 1'b0;
        #1;
        chk("mid.out_data",  64'(ia.out_data),  64'd0);
        chk("mid.out_count", 64'(ia.out_count), 64'd0);
        chk("mid.out_valid", 64'(ia.out_valid), 64'd0);
        chk("mid.in_ready",  64'(ia.in_ready),  64'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        beat_a(32'd1, 1'b0, 1'b0, 0);
        beat_a(32'd2, 1'b1, 1'b0, 0);
        take_a("post_rst", 32'd2, 16'd1, 16'd2, 1'b0);

        // 17 beats into a 4-bit count: wraps once, max lands on index 16
        for (int i = 0; i < 17; i++)
            beat_o((i == 16) ? 32'd100 : 32'(i), (i == 16));
        chk("ovf.valid", 64'(io.out_valid), 64'd1);
        chk("ovf.data",  64'(io.out_data),  64'd100);
        chk("ovf.flag",  64'(io.out_ovf),   64'd1);
        chk("ovf.count", 64'(io.out_count), 64'd1);
        chk("ovf.idx",   64'(io.out_idx),   64'd0);
        io.out_ready = 1'b1;
        @(posedge clk); #1;
        io.out_ready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
